// File: rtl/mcyc_mem_if.sv
// Memory access unit for the multicycle RISC-V core: loads with lane extraction
// and extension, word stores, and sub-word stores as SRAM read-modify-write.
module mcyc_mem_if #(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic              we,
  input  logic [31:0]       addr,
  input  logic [31:0]       wd,
  input  logic [2:0]        dt,
  output logic [31:0]       rdata,
  output logic              done,
  output logic              busy,
  output logic              err,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ack
);

  // Handshake: mem_req rises with entry into an access state and holds, with
  // mem_we/mem_addr/mem_wdata stable, until the edge that samples mem_ack=1;
  // each such edge completes exactly one SRAM access.
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_RD     = 3'd1,
    S_WR     = 3'd2,
    S_RMW_RD = 3'd3,
    S_RMW_WR = 3'd4,
    S_DONE   = 3'd5
  } state_t;

  state_t      state;
  logic [1:0]  lane_r;
  logic [2:0]  dt_r;
  logic [15:0] wd_lo_r;

  logic        illegal;
  logic [7:0]  rd_byte;
  logic [15:0] rd_half;
  logic [31:0] load_val;
  logic [31:0] merged;

  logic unused_addr_hi;
  assign unused_addr_hi = ^addr[31:ADDR_W+2];

  always_comb begin
    illegal = 1'b0;
    case (dt)
      3'b000:  illegal = 1'b0;
      3'b001:  illegal = addr[0];
      3'b010:  illegal = (addr[1:0] != 2'b00);
      3'b100:  illegal = we;
      3'b101:  illegal = we | addr[0];
      default: illegal = 1'b1;
    endcase
  end

  always_comb begin
    rd_byte = mem_rdata[7:0];
    case (lane_r)
      2'd0:    rd_byte = mem_rdata[7:0];
      2'd1:    rd_byte = mem_rdata[15:8];
      2'd2:    rd_byte = mem_rdata[23:16];
      default: rd_byte = mem_rdata[31:24];
    endcase
    rd_half = lane_r[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (dt_r)
      3'b000:  load_val = {{24{rd_byte[7]}}, rd_byte};
      3'b100:  load_val = {24'd0, rd_byte};
      3'b001:  load_val = {{16{rd_half[15]}}, rd_half};
      3'b101:  load_val = {16'd0, rd_half};
      default: load_val = mem_rdata;
    endcase
  end

  // Only byte and half stores reach the merge; dt_r[1:0]=00 selects byte.
  always_comb begin
    merged = mem_rdata;
    if (dt_r[1:0] == 2'b00) begin
      case (lane_r)
        2'd0:    merged[7:0]   = wd_lo_r[7:0];
        2'd1:    merged[15:8]  = wd_lo_r[7:0];
        2'd2:    merged[23:16] = wd_lo_r[7:0];
        default: merged[31:24] = wd_lo_r[7:0];
      endcase
    end else if (lane_r[1]) begin
      merged[31:16] = wd_lo_r;
    end else begin
      merged[15:0] = wd_lo_r;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      lane_r    <= 2'd0;
      dt_r      <= 3'd0;
      wd_lo_r   <= 16'd0;
      rdata     <= 32'd0;
      done      <= 1'b0;
      busy      <= 1'b0;
      err       <= 1'b0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= 32'd0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        S_IDLE: begin
          if (req) begin
            lane_r   <= addr[1:0];
            dt_r     <= dt;
            wd_lo_r  <= wd[15:0];
            mem_addr <= addr[ADDR_W+1:2];
            busy     <= 1'b1;
            if (illegal) begin
              state <= S_DONE;
              done  <= 1'b1;
              err   <= 1'b1;
            end else if (!we) begin
              state   <= S_RD;
              mem_req <= 1'b1;
              mem_we  <= 1'b0;
            end else if (dt[1:0] == 2'b10) begin
              state     <= S_WR;
              mem_req   <= 1'b1;
              mem_we    <= 1'b1;
              mem_wdata <= wd;
            end else begin
              state   <= S_RMW_RD;
              mem_req <= 1'b1;
              mem_we  <= 1'b0;
            end
          end
        end
        S_RD: begin
          if (mem_ack) begin
            rdata   <= load_val;
            mem_req <= 1'b0;
            state   <= S_DONE;
            done    <= 1'b1;
          end
        end
        // The write half of RMW keeps mem_req high but is a fresh access.
        S_RMW_RD: begin
          if (mem_ack) begin
            mem_wdata <= merged;
            mem_we    <= 1'b1;
            state     <= S_RMW_WR;
          end
        end
        S_WR, S_RMW_WR: begin
          if (mem_ack) begin
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
            state   <= S_DONE;
            done    <= 1'b1;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state   <= S_IDLE;
          busy    <= 1'b0;
          mem_req <= 1'b0;
          mem_we  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mcyc_mem_if.sv
// Bench for mcyc_mem_if: SRAM model with programmable ack delay, directed
// accesses with hand-computed results, and a done-driven scoreboard monitor.
module tb_mcyc_mem_if;
  localparam int ADDR_W = 10;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              req = 1'b0;
  logic              we = 1'b0;
  logic [31:0]       addr = 32'd0;
  logic [31:0]       wd = 32'd0;
  logic [2:0]        dt = 3'd0;
  logic [31:0]       rdata;
  logic              done, busy, err;
  logic              mem_req, mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata = 32'd0;
  logic              mem_ack = 1'b0;

  mcyc_mem_if #(.ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .wd(wd), .dt(dt),
    .rdata(rdata), .done(done), .busy(busy), .err(err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );

  // Clock/reset
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_miss = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // SRAM model
  logic [31:0] sram [0:1023];
  logic        preload = 1'b1;
  int          ack_delay = 0;
  int          wait_cnt = 0;
  int          rd_cnt = 0;
  int          wr_cnt = 0;
  int          req_cycles = 0;
  logic [ADDR_W-1:0] last_wr_addr = '0;
  logic        prev_req = 1'b0;
  logic        prev_ack = 1'b0;
  logic [42:0] prev_bundle = '0;

  always @(posedge clk) begin
    if (preload) begin
      sram[4] <= 32'h8899AABB;
      sram[5] <= 32'h00000000;
    end else if (mem_req && mem_ack) begin
      if (mem_we) begin
        sram[mem_addr] <= mem_wdata;
        last_wr_addr   <= mem_addr;
        wr_cnt         <= wr_cnt + 1;
      end else begin
        rd_cnt <= rd_cnt + 1;
      end
    end
  end

  always @(negedge clk) begin
    if (mem_req && prev_req && !prev_ack)
      check("req_stable", {21'd0, mem_we, mem_addr, mem_wdata}, {21'd0, prev_bundle});
    if (!mem_req || mem_ack) wait_cnt = 0;
    prev_req    = mem_req;
    prev_bundle = {mem_we, mem_addr, mem_wdata};
    if (mem_req) begin
      req_cycles++;
      if (wait_cnt >= ack_delay) begin
        mem_ack   = 1'b1;
        mem_rdata = sram[mem_addr];
      end else begin
        mem_ack   = 1'b0;
        mem_rdata = 32'hxxxxxxxx;
        wait_cnt++;
      end
    end else begin
      mem_ack = 1'b0;
    end
    prev_ack = mem_ack;
  end

  // Scoreboard: {latency[7:0], err, rdata[31:0]}
  logic [40:0] exp_q[$];
  int          req_cyc = 0;
  string       cur_name = "";
  logic        done_prev = 1'b0;

  always @(negedge clk) begin
    logic [40:0] e;
    if (done) begin
      check("done_width", {63'd0, done_prev}, 64'd0);
      if (exp_q.size() == 0) begin
        check("spurious_done", 64'(exp_q.size()), 64'd1);
      end else begin
        e = exp_q.pop_front();
        check({cur_name, "_rdata"}, {32'd0, rdata}, {32'd0, e[31:0]});
        check({cur_name, "_err"}, {63'd0, err}, {63'd0, e[32]});
        check({cur_name, "_lat"}, 64'(cyc - req_cyc), 64'(e[40:33]));
      end
    end
    done_prev = done;
  end

  // Driver
  task automatic do_access(input string name, input logic w, input logic [31:0] a,
                           input logic [31:0] d, input logic [2:0] t,
                           input logic [31:0] exp_rd, input logic exp_err, input int exp_lat,
                           input int exp_reads, input int exp_writes, input int exp_reqc,
                           input int delay, input bit nag);
    int rd0, wr0, rq0;
    logic seen;
    ack_delay = delay;
    @(negedge clk);
    rd0 = rd_cnt; wr0 = wr_cnt; rq0 = req_cycles;
    req = 1'b1; we = w; addr = a; wd = d; dt = t;
    req_cyc = cyc;
    cur_name = name;
    exp_q.push_back({8'(exp_lat), exp_err, exp_rd});
    @(negedge clk);
    req = 1'b0;
    seen = done;
    for (int i = 0; i < 50 && !seen; i++) begin
      if (nag) begin
        req = ~req; we = 1'b1; addr = 32'h10; wd = 32'h0; dt = 3'b010;
      end
      @(negedge clk);
      seen = done;
    end
    req = 1'b0;
    check({name, "_done_seen"}, {63'd0, seen}, 64'd1);
    check({name, "_reads"}, 64'(rd_cnt - rd0), 64'(exp_reads));
    check({name, "_writes"}, 64'(wr_cnt - wr0), 64'(exp_writes));
    check({name, "_req_cycles"}, 64'(req_cycles - rq0), 64'(exp_reqc));
  endtask

  initial begin
    logic seen;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    preload = 1'b0;
    @(negedge clk);
    check("rst_outputs", {29'd0, done, busy, err, 21'd0, mem_req, mem_we, mem_addr},
          64'd0);
    check("rst_rdata_wdata", {rdata, mem_wdata}, 64'd0);

    // Loads of word 0x8899AABB at byte 0x10, zero-wait
    do_access("lw10",  1'b0, 32'h10, 32'h0, 3'b010, 32'h8899AABB, 1'b0, 2, 1, 0, 1, 0, 0);
    do_access("lb11",  1'b0, 32'h11, 32'h0, 3'b000, 32'hFFFFFFAA, 1'b0, 2, 1, 0, 1, 0, 0);
    do_access("lbu13", 1'b0, 32'h13, 32'h0, 3'b100, 32'h00000088, 1'b0, 2, 1, 0, 1, 0, 0);
    do_access("lh12",  1'b0, 32'h12, 32'h0, 3'b001, 32'hFFFF8899, 1'b0, 2, 1, 0, 1, 0, 0);
    do_access("lhu10", 1'b0, 32'h10, 32'h0, 3'b101, 32'h0000AABB, 1'b0, 2, 1, 0, 1, 0, 0);

    // Sub-word stores via RMW
    do_access("sb12", 1'b1, 32'h12, 32'h123456CC, 3'b000, 32'h0000AABB, 1'b0, 3, 1, 1, 2, 0, 0);
    check("sb12_word", {32'd0, sram[4]}, 64'h88CCAABB);
    check("sb12_waddr", 64'(last_wr_addr), 64'd4);
    do_access("sh10", 1'b1, 32'h10, 32'h00001234, 3'b001, 32'h0000AABB, 1'b0, 3, 1, 1, 2, 0, 0);
    check("sh10_word", {32'd0, sram[4]}, 64'h88CC1234);

    // Word store with 3 wait cycles
    do_access("sw14", 1'b1, 32'h14, 32'hDEADBEEF, 3'b010, 32'h0000AABB, 1'b0, 5, 0, 1, 4, 3, 0);
    check("sw14_word", {32'd0, sram[5]}, 64'hDEADBEEF);
    check("sw14_waddr", 64'(last_wr_addr), 64'd5);

    // Illegal accesses
    do_access("lw12_mis", 1'b0, 32'h12, 32'h0, 3'b010, 32'h0000AABB, 1'b1, 1, 0, 0, 0, 0, 0);
    do_access("lh13_mis", 1'b0, 32'h13, 32'h0, 3'b001, 32'h0000AABB, 1'b1, 1, 0, 0, 0, 0, 0);
    do_access("dt011",    1'b0, 32'h10, 32'h0, 3'b011, 32'h0000AABB, 1'b1, 1, 0, 0, 0, 0, 0);
    do_access("sbu_ill",  1'b1, 32'h10, 32'h0, 3'b100, 32'h0000AABB, 1'b1, 1, 0, 0, 0, 0, 0);
    do_access("lw10_ok",  1'b0, 32'h10, 32'h0, 3'b010, 32'h88CC1234, 1'b0, 2, 1, 0, 1, 0, 0);

    // Reset during the RMW write wait
    ack_delay = 3;
    @(negedge clk);
    req = 1'b1; we = 1'b1; addr = 32'h10; wd = 32'h000000FF; dt = 3'b000;
    @(negedge clk);
    req = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      if (mem_req && mem_we) seen = 1'b1;
      else @(negedge clk);
    end
    check("rmw_wr_reached", {63'd0, seen}, 64'd1);
    #2 rst = 1'b1;
    #1;
    check("rst_mid_req_busy", {62'd0, mem_req, busy}, 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("rst_mid_word", {32'd0, sram[4]}, 64'h88CC1234);
    check("rst_mid_rdata", {32'd0, rdata}, 64'd0);
    do_access("lw10_post", 1'b0, 32'h10, 32'h0, 3'b010, 32'h88CC1234, 1'b0, 2, 1, 0, 1, 0, 0);

    // req toggled while busy must be ignored
    do_access("lw14_nag", 1'b0, 32'h14, 32'h0, 3'b010, 32'hDEADBEEF, 1'b0, 4, 1, 0, 3, 2, 1);
    check("nag_word4", {32'd0, sram[4]}, 64'h88CC1234);
    repeat (3) @(negedge clk);
    check("idle_after", {62'd0, busy, mem_req}, 64'd0);
    check("queue_empty", 64'(exp_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end
endmodule
